multiplier_t_c3x3_f0_27b_27b: RTL and testbench

Configurable multiplier block for the PIRDSP-style DSP datapath, with two modes:
- One 27x27 multiply, with independent signedness per operand.
- Three SIMD lanes, each computing a sum of three 9x9 products.

---
 rtl/multiplier_t_c3x3_f0_27b_27b.sv | 92 +++++++++
 tb/tb_multiplier_t_c3x3_f0_27b_27b.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multiplier_t_c3x3_f0_27b_27b.sv
// multiplier_t_c3x3_f0_27b_27b: 27x27 or 3-lane sum-of-three-9x9 multiplier, redundant registered result.
// Define MULT_INPUT_REG_EN to add a reset-cleared input register stage (latency 2).
module multiplier_t_c3x3_f0_27b_27b (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [80:0] a,
  input  logic [80:0] b,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [1:0]  mode,
  output logic [53:0] result_0,
  output logic [53:0] result_1,
  output logic [5:0]  result_SIMD_carry
);
  logic [80:0] a_s, b_s;
  logic        as_s, bs_s, simd;
  logic        unused_mode;
  assign unused_mode = mode[1];
`ifdef MULT_INPUT_REG_EN
  logic [80:0] a_q, b_q;
  logic        as_q, bs_q, simd_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      as_q   <= 1'b0;
      bs_q   <= 1'b0;
      simd_q <= 1'b0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      as_q   <= a_sign;
      bs_q   <= b_sign;
      simd_q <= mode[0];
    end
  end
  assign a_s  = a_q;
  assign b_s  = b_q;
  assign as_s = as_q;
  assign bs_s = bs_q;
  assign simd = simd_q;
`else
  assign a_s  = a;
  assign b_s  = b;
  assign as_s = a_sign;
  assign bs_s = b_sign;
  assign simd = mode[0];
`endif
  // Nine shared 10x10 signed multipliers: chunk pairs (g,g) in SIMD, (g/3,g%3) in 27x27.
  logic [19:0] pp [9];
  for (genvar g = 0; g < 9; g++) begin : g_mul
    logic [8:0] ac, bc;
    logic       ae, be;
    logic [9:0] ax, bx;
    assign ac = simd ? a_s[9*g +: 9] : a_s[9*(g/3) +: 9];
    assign bc = simd ? b_s[9*g +: 9] : b_s[9*(g%3) +: 9];
    assign ae = as_s & (simd | (g / 3 == 2));
    assign be = bs_s & (simd | (g % 3 == 2));
    assign ax = {ae & ac[8], ac};
    assign bx = {be & bc[8], bc};
    assign pp[g] = {{10{ax[9]}}, ax} * {{10{bx[9]}}, bx};
  end
  logic [53:0] even, odd, r0_d, r1_d, r0_q, r1_q;
  logic [5:0]  c_d, c_q;
  logic [19:0] lane [3];
  always_comb begin
    even = '0;
    odd  = '0;
    lane = '{default: '0};
    for (int m = 0; m < 9; m++)
      if (((m / 3 + m % 3) % 2) == 0) even = even + ({{34{pp[m][19]}}, pp[m]} << (9 * (m / 3 + m % 3)));
      else odd = odd + ({{34{pp[m][19]}}, pp[m]} << (9 * (m / 3 + m % 3)));
    for (int k = 0; k < 3; k++) lane[k] = pp[3*k] + pp[3*k+1] + pp[3*k+2];
    r0_d = simd ? {lane[2][17:0], lane[1][17:0], lane[0][17:0]} : even;
    r1_d = simd ? '0 : odd;
    c_d  = simd ? {lane[2][19:18], lane[1][19:18], lane[0][19:18]} : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r0_q <= '0;
      r1_q <= '0;
      c_q  <= '0;
    end else begin
      r0_q <= r0_d;
      r1_q <= r1_d;
      c_q  <= c_d;
    end
  end
  assign result_0          = r0_q;
  assign result_1          = r1_q;
  assign result_SIMD_carry = c_q;
endmodule

// File: tb/tb_multiplier_t_c3x3_f0_27b_27b.sv
// tb_multiplier_t_c3x3_f0_27b_27b: directed table, reset sequences and random check against ideal products.
module tb_multiplier_t_c3x3_f0_27b_27b;
`ifdef MULT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic [80:0] a, b;
  logic        a_sign, b_sign;
  logic [1:0]  mode;
  logic [53:0] result_0, result_1;
  logic [5:0]  result_SIMD_carry;
  int n_cmp = 0;
  int n_bad = 0;

  multiplier_t_c3x3_f0_27b_27b dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .a_sign(a_sign), .b_sign(b_sign),
    .mode(mode), .result_0(result_0), .result_1(result_1), .result_SIMD_carry(result_SIMD_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [80:0] a, b;
    logic        as, bs, md;
    logic [53:0] e27;
    logic [59:0] el;
  } vec_t;
  vec_t vecs[$];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check(input string nm, input logic md, input logic [53:0] e27, input logic [59:0] el);
    logic [53:0] s;
    logic [19:0] r;
    if (!md) begin
      s = result_0 + result_1;
      cmp({nm, " sum"}, 64'(s), 64'(e27));
      cmp({nm, " carry"}, 64'(result_SIMD_carry), 64'd0);
    end else
      for (int k = 0; k < 3; k++) begin
        r = {result_SIMD_carry[2*k +: 2], result_0[18*k +: 18]} + {2'b00, result_1[18*k +: 18]};
        cmp($sformatf("%s lane%0d", nm, k), 64'(r), 64'(el[20*k +: 20]));
      end
  endtask

  function automatic logic [53:0] m27(input logic [80:0] x, input logic [80:0] y, input logic xs, input logic ys);
    logic [63:0] p, q;
    p = xs ? {{37{x[26]}}, x[26:0]} : {37'b0, x[26:0]};
    q = ys ? {{37{y[26]}}, y[26:0]} : {37'b0, y[26:0]};
    p = p * q;
    return p[53:0];
  endfunction

  function automatic logic [59:0] msimd(input logic [80:0] x, input logic [80:0] y, input logic xs, input logic ys);
    logic [59:0] res;
    logic [31:0] acc, p, q;
    for (int k = 0; k < 3; k++) begin
      acc = 0;
      for (int j = 3 * k; j < 3 * k + 3; j++) begin
        p = xs ? {{23{x[9*j+8]}}, x[9*j +: 9]} : {23'b0, x[9*j +: 9]};
        q = ys ? {{23{y[9*j+8]}}, y[9*j +: 9]} : {23'b0, y[9*j +: 9]};
        acc = acc + p * q;
      end
      res[20*k +: 20] = acc[19:0];
    end
    return res;
  endfunction

  task automatic apply(input vec_t v);
    a = v.a; b = v.b; a_sign = v.as; b_sign = v.bs; mode = {1'b0, v.md};
  endtask

  initial begin
    vecs.push_back('{"uu_max",    81'h7FFFFFF, 81'h7FFFFFF, 1'b0, 1'b0, 1'b0, 54'h3FFFFFF0000001, 60'h0});
    vecs.push_back('{"ss_min",    81'h4000000, 81'h4000000, 1'b1, 1'b1, 1'b0, 54'h10000000000000, 60'h0});
    vecs.push_back('{"us_m3",     81'd3,       81'h7FFFFFF, 1'b0, 1'b1, 1'b0, 54'h3FFFFFFFFFFFFD, 60'h0});
    vecs.push_back('{"ss_m1m1",   81'h7FFFFFF, 81'h7FFFFFF, 1'b1, 1'b1, 1'b0, 54'h1,              60'h0});
    vecs.push_back('{"us_maxm1",  81'h7FFFFFF, 81'h7FFFFFF, 1'b0, 1'b1, 1'b0, 54'h3FFFFFF8000001, 60'h0});
    vecs.push_back('{"uu_upper",  {54'h2AAAAAAAAAAAAA, 27'd2}, 81'd1000, 1'b0, 1'b0, 1'b0, 54'd2000, 60'h0});
    vecs.push_back('{"simd_uu",   {9{9'h1FF}}, {9{9'h1FF}}, 1'b0, 1'b0, 1'b1, 54'h0, {3{20'hBF403}}});
    vecs.push_back('{"simd_ss",   {9{9'h100}}, {9{9'h100}}, 1'b1, 1'b1, 1'b1, 54'h0, {3{20'h30000}}});
    vecs.push_back('{"simd_su",   {9{9'h1FF}}, {9{9'h1FF}}, 1'b1, 1'b0, 1'b1, 54'h0, {3{20'hFFA03}}});
    vecs.push_back('{"simd_us",   {9{9'h100}}, {9{9'h1FF}}, 1'b0, 1'b1, 1'b1, 54'h0, {3{20'hFFD00}}});
    vecs.push_back('{"simd_lanes",
                     {9'h1FF, 9'h1FF, 9'h1FF, 9'd0, 9'd0, 9'd0, 9'd3, 9'd2, 9'd1},
                     {9'd0, 9'd0, 9'd1, 9'd7, 9'd7, 9'd7, 9'd6, 9'd5, 9'd4},
                     1'b0, 1'b0, 1'b1, 54'h0, {20'h001FF, 20'h00000, 20'h00020}});
    // Reset with all-ones operands
    reset_n = 1'b0; a = '1; b = '1; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset r0", 64'(result_0), 64'd0);
    cmp("reset r1", 64'(result_1), 64'd0);
    cmp("reset carry", 64'(result_SIMD_carry), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(vecs[0]);
    repeat (LAT) @(posedge clk);
    #1;
    check("post_reset", 1'b0, vecs[0].e27, 60'h0);
    // Back-to-back table stream with mode and sign changing every cycle
    for (int i = 0; i < vecs.size() + LAT - 1; i++) begin
      @(negedge clk);
      if (i < vecs.size()) apply(vecs[i]);
      @(posedge clk);
      #1;
      if (i >= LAT - 1) check(vecs[i-LAT+1].nm, vecs[i-LAT+1].md, vecs[i-LAT+1].e27, vecs[i-LAT+1].el);
    end
    // Mid-stream reset, then recovery
    @(negedge clk);
    apply(vecs[6]);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    cmp("midreset r0", 64'(result_0), 64'd0);
    cmp("midreset carry", 64'(result_SIMD_carry), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(vecs[7]);
    repeat (LAT) @(posedge clk);
    #1;
    check("after_midreset", 1'b1, 54'h0, vecs[7].el);
    // Random regression over every mode and sign combination
    for (int c = 0; c < 8; c++) begin
      for (int n = 0; n < 400; n++) begin
        @(negedge clk);
        a = {17'($urandom()), $urandom(), $urandom()};
        b = {17'($urandom()), $urandom(), $urandom()};
        a_sign = c[0]; b_sign = c[1]; mode = {1'($urandom_range(0, 1)), c[2]};
        repeat (LAT) @(posedge clk);
        #1;
        check($sformatf("rand c%0d n%0d", c, n), c[2], m27(a, b, c[0], c[1]), msimd(a, b, c[0], c[1]));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
